// File: rtl/ascii_key_encoder.sv
// ascii_key_encoder: turns one accepted ASCII character into a sequence of
// keyboard key events (optional shift down, key down, key up, optional
// shift up), each a one-cycle o_Enable strobe separated by GAP_CYCLES idle
// cycles.
// Optional feature: define ASCII_KEY_ENCODER_CTRL_EN to also map space,
// line feed and backspace; without it those characters raise o_Error.
module ascii_key_encoder #(
  parameter int GAP_CYCLES = 2
) (
  input  logic       w_Clk,
  input  logic       w_Reset,
  input  logic [7:0] w_Char,
  input  logic       w_Valid,
  output logic       o_Ready,
  output logic [7:0] o_KeyEvent,
  output logic       o_Enable,
  output logic       o_Error
);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_DN,
    KEY_DN,
    KEY_UP,
    SHIFT_UP,
    GAP
  } state_t;

  localparam logic [7:0] SHIFT_CODE = 8'h72;
  localparam bit         HAS_GAP    = (GAP_CYCLES > 0);
  // Gap counter is loaded with the index of the final gap cycle and counts
  // down to zero, so a gap of N cycles spends exactly N cycles in GAP.
  localparam logic [7:0] GAP_LAST   = HAS_GAP ? 8'(GAP_CYCLES - 1) : 8'd0;

  state_t     state, state_nxt;
  state_t     ret_q, ret_nxt;      // event state to resume after the gap
  logic [7:0] gap_cnt, gap_cnt_nxt;
  logic [6:0] code_q, code_nxt;    // latched keycode of the character
  logic       shift_q, shift_nxt;  // latched character needs shift
  logic [7:0] key_q, key_nxt;      // last emitted event, held between strobes
  logic       err_q, err_nxt;

  logic       dec_ok;
  logic       dec_shift;
  logic [6:0] dec_code;
  state_t     succ;

  // Character decode result: {supported, shifted, keycode}. Keycode math is
  // done in 8 bits and truncated to 7, which forces bit7 to zero.
  function automatic logic [8:0] decode(input logic [7:0] ch);
    logic [8:0] r;
    r = '0;
    if (ch >= 8'h61 && ch <= 8'h7A)
      r = {2'b10, 7'(ch - 8'h5D)};
    else if (ch >= 8'h41 && ch <= 8'h5A)
      r = {2'b11, 7'(ch - 8'h3D)};
    else if (ch >= 8'h31 && ch <= 8'h39)
      r = {2'b10, 7'(ch - 8'h13)};
    else if (ch == 8'h30)
      r = {2'b10, 7'h27};
    else if (ch == 8'h29)
      r = {2'b11, 7'h27};
`ifdef ASCII_KEY_ENCODER_CTRL_EN
    else if (ch == 8'h20)
      r = {2'b10, 7'h2C};
    else if (ch == 8'h0A)
      r = {2'b10, 7'h28};
    else if (ch == 8'h08)
      r = {2'b10, 7'h2A};
`endif
    return r;
  endfunction

  // True for the four states that put an event on the bus.
  function automatic logic is_evt(input state_t s);
    return (s == SHIFT_DN) || (s == KEY_DN) || (s == KEY_UP) || (s == SHIFT_UP);
  endfunction

  // Event that follows a given event state; IDLE ends the sequence.
  function automatic state_t after_evt(input state_t s, input logic shifted);
    state_t r;
    case (s)
      SHIFT_DN: r = KEY_DN;
      KEY_DN:   r = KEY_UP;
      KEY_UP:   r = shifted ? SHIFT_UP : IDLE;
      default:  r = IDLE;
    endcase
    return r;
  endfunction

  // Bus value for an event state.
  function automatic logic [7:0] evt_val(input state_t s, input logic [6:0] code);
    logic [7:0] r;
    case (s)
      SHIFT_DN: r = SHIFT_CODE;
      KEY_DN:   r = {1'b0, code};
      KEY_UP:   r = {1'b1, code};
      SHIFT_UP: r = {1'b1, SHIFT_CODE[6:0]};
      default:  r = 8'h00;
    endcase
    return r;
  endfunction

  assign {dec_ok, dec_shift, dec_code} = decode(w_Char);

  // Next-state logic: accept in IDLE, step through events and gaps.
  always_comb begin
    state_nxt   = state;
    ret_nxt     = ret_q;
    gap_cnt_nxt = gap_cnt;
    code_nxt    = code_q;
    shift_nxt   = shift_q;
    key_nxt     = key_q;
    err_nxt     = 1'b0;
    succ        = after_evt(state, shift_q);

    case (state)
      IDLE: begin
        if (w_Valid) begin
          if (dec_ok) begin
            code_nxt  = dec_code;
            shift_nxt = dec_shift;
            state_nxt = dec_shift ? SHIFT_DN : KEY_DN;
          end else begin
            // Unsupported character: flag it and stay ready.
            err_nxt = 1'b1;
          end
        end
      end
      SHIFT_DN, KEY_DN, KEY_UP, SHIFT_UP: begin
        if (HAS_GAP) begin
          state_nxt   = GAP;
          ret_nxt     = succ;
          gap_cnt_nxt = GAP_LAST;
        end else begin
          state_nxt = succ;
        end
      end
      GAP: begin
        if (gap_cnt == 8'd0)
          state_nxt = ret_q;
        else
          gap_cnt_nxt = gap_cnt - 8'd1;
      end
      default: state_nxt = IDLE;
    endcase

    // Load the bus value only when entering an event state, so it holds
    // the last emitted event through gaps and idle.
    if (is_evt(state_nxt))
      key_nxt = evt_val(state_nxt, code_nxt);
  end

  // State and datapath registers; reset aborts any sequence in flight.
  always_ff @(posedge w_Clk) begin
    if (w_Reset) begin
      state   <= IDLE;
      ret_q   <= IDLE;
      gap_cnt <= 8'd0;
      code_q  <= 7'd0;
      shift_q <= 1'b0;
      key_q   <= 8'h00;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      ret_q   <= ret_nxt;
      gap_cnt <= gap_cnt_nxt;
      code_q  <= code_nxt;
      shift_q <= shift_nxt;
      key_q   <= key_nxt;
      err_q   <= err_nxt;
    end
  end

  assign o_Ready    = (state == IDLE);
  assign o_Enable   = is_evt(state);
  assign o_KeyEvent = key_q;
  assign o_Error    = err_q;

endmodule

// File: tb/tb_ascii_key_encoder.sv
// Directed bench for ascii_key_encoder: a character table run on a
// GAP_CYCLES=2 instance, plus hand sequences for reset mid-sequence and
// back-to-back characters on a GAP_CYCLES=0 instance.
module tb_ascii_key_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid2, valid0;
  logic [7:0] ch2, ch0;
  logic       ready2, ready0, en2, en0, err2, err0;
  logic [7:0] key2, key0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ascii_key_encoder #(.GAP_CYCLES(2)) dut2 (
    .w_Clk(clk), .w_Reset(rst), .w_Char(ch2), .w_Valid(valid2),
    .o_Ready(ready2), .o_KeyEvent(key2), .o_Enable(en2), .o_Error(err2)
  );

  ascii_key_encoder #(.GAP_CYCLES(0)) dut0 (
    .w_Clk(clk), .w_Reset(rst), .w_Char(ch0), .w_Valid(valid0),
    .o_Ready(ready0), .o_KeyEvent(key0), .o_Enable(en0), .o_Error(err0)
  );

  typedef struct {
    logic [7:0]      ch;
    bit              err;
    int              n;
    logic [3:0][7:0] ev;
  } vec_t;

  function automatic vec_t mk(logic [7:0] ch, bit err, int n,
                              logic [7:0] e0, logic [7:0] e1,
                              logic [7:0] e2, logic [7:0] e3);
    vec_t v;
    v.ch = ch; v.err = err; v.n = n; v.ev = {e3, e2, e1, e0};
    return v;
  endfunction

  // Compare {ready, enable, error, key_event}.
  task automatic check(string name, logic [10:0] act, logic [10:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got rdy/en/err/key=%b/%b/%b/%h expected %b/%b/%b/%h",
               name, act[10], act[9], act[8], act[7:0],
               exp[10], exp[9], exp[8], exp[7:0]);
    end
  endtask

  initial begin
    vec_t        vecs[$];
    vec_t        v;
    logic [7:0]  last;
    logic [10:0] exp;
    logic [10:0] seq_r[13];
    logic [10:0] seq_z[11];
    int          lastcyc, idx;
    bit          e;

    // Character table: hand-computed event sequences at GAP_CYCLES=2.
    vecs.push_back(mk(8'h61, 0, 2, 8'h04, 8'h84, 8'h00, 8'h00)); // a
    vecs.push_back(mk(8'h5A, 0, 4, 8'h72, 8'h1D, 8'h9D, 8'hF2)); // Z
    vecs.push_back(mk(8'h7A, 0, 2, 8'h1D, 8'h9D, 8'h00, 8'h00)); // z
    vecs.push_back(mk(8'h41, 0, 4, 8'h72, 8'h04, 8'h84, 8'hF2)); // A
    vecs.push_back(mk(8'h31, 0, 2, 8'h1E, 8'h9E, 8'h00, 8'h00)); // 1
    vecs.push_back(mk(8'h39, 0, 2, 8'h26, 8'hA6, 8'h00, 8'h00)); // 9
    vecs.push_back(mk(8'h30, 0, 2, 8'h27, 8'hA7, 8'h00, 8'h00)); // 0
    vecs.push_back(mk(8'h29, 0, 4, 8'h72, 8'h27, 8'hA7, 8'hF2)); // )
    vecs.push_back(mk(8'h21, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00)); // !
    vecs.push_back(mk(8'h40, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00)); // @
    vecs.push_back(mk(8'h5B, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00)); // [
    vecs.push_back(mk(8'h60, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00)); // `
    vecs.push_back(mk(8'h7B, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00)); // {
    vecs.push_back(mk(8'h3A, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00)); // :
    vecs.push_back(mk(8'hE1, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00)); // high bit
`ifdef ASCII_KEY_ENCODER_CTRL_EN
    vecs.push_back(mk(8'h20, 0, 2, 8'h2C, 8'hAC, 8'h00, 8'h00));
    vecs.push_back(mk(8'h0A, 0, 2, 8'h28, 8'hA8, 8'h00, 8'h00));
    vecs.push_back(mk(8'h08, 0, 2, 8'h2A, 8'hAA, 8'h00, 8'h00));
`else
    vecs.push_back(mk(8'h20, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(8'h0A, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(8'h08, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00));
`endif
    vecs.push_back(mk(8'h51, 0, 4, 8'h72, 8'h14, 8'h94, 8'hF2)); // Q

    rst = 1'b1; valid2 = 1'b0; valid0 = 1'b0; ch2 = 8'h00; ch0 = 8'h00;
    repeat (2) @(negedge clk);
    check("reset_g2", {ready2, en2, err2, key2}, {3'b100, 8'h00});
    check("reset_g0", {ready0, en0, err0, key0}, {3'b100, 8'h00});
    rst = 1'b0;
    @(negedge clk);

    // Table: accept in c0, then check every cycle until ready returns.
    // While busy, w_Valid is held high with junk that must be ignored.
    last = 8'h00;
    foreach (vecs[i]) begin
      v = vecs[i];
      check($sformatf("vec%0d_c0", i), {ready2, en2, err2, key2}, {3'b100, last});
      ch2 = v.ch; valid2 = 1'b1;
      lastcyc = (v.n == 0) ? 2 : 3 * v.n + 1;
      for (int cyc = 1; cyc <= lastcyc; cyc++) begin
        @(negedge clk);
        idx = (cyc - 1) / 3;
        e = (v.n > 0) && ((cyc - 1) % 3 == 0) && (idx < v.n);
        if (e) last = v.ev[idx];
        exp = {(v.n == 0) || (cyc == 3 * v.n + 1), e, v.err && (cyc == 1), last};
        check($sformatf("vec%0d_%h_c%0d", i, v.ch, cyc), {ready2, en2, err2, key2}, exp);
        valid2 = (v.n > 0) && (cyc <= 3 * v.n);
        ch2 = 8'h71;
      end
    end

    // Reset during the gap after KEY_DN of 'Q'; a valid held during reset
    // must also be ignored, and no closing events may appear afterwards.
    seq_r[1]  = {3'b010, 8'h72};
    seq_r[2]  = {3'b000, 8'h72};
    seq_r[3]  = {3'b000, 8'h72};
    seq_r[4]  = {3'b010, 8'h14};
    seq_r[5]  = {3'b000, 8'h14};
    for (int c = 6; c <= 12; c++) seq_r[c] = {3'b100, 8'h00};
    check("rst_seq_c0", {ready2, en2, err2, key2}, {3'b100, last});
    ch2 = 8'h51; valid2 = 1'b1;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      check($sformatf("rst_seq_c%0d", cyc), {ready2, en2, err2, key2}, seq_r[cyc]);
      valid2 = 1'b0;
      if (cyc == 5 || cyc == 6) begin rst = 1'b1; valid2 = 1'b1; ch2 = 8'h61; end
      else rst = 1'b0;
    end

    // GAP_CYCLES=0: '0' then ')' back-to-back, then '!' for an error pulse.
    seq_z[1]  = {3'b010, 8'h27};
    seq_z[2]  = {3'b010, 8'hA7};
    seq_z[3]  = {3'b100, 8'hA7};
    seq_z[4]  = {3'b010, 8'h72};
    seq_z[5]  = {3'b010, 8'h27};
    seq_z[6]  = {3'b010, 8'hA7};
    seq_z[7]  = {3'b010, 8'hF2};
    seq_z[8]  = {3'b100, 8'hF2};
    seq_z[9]  = {3'b101, 8'hF2};
    seq_z[10] = {3'b100, 8'hF2};
    check("g0_c0", {ready0, en0, err0, key0}, {3'b100, 8'h00});
    ch0 = 8'h30; valid0 = 1'b1;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      check($sformatf("g0_c%0d", cyc), {ready0, en0, err0, key0}, seq_z[cyc]);
      valid0 = 1'b0;
      if (cyc == 3) begin valid0 = 1'b1; ch0 = 8'h29; end
      if (cyc == 8) begin valid0 = 1'b1; ch0 = 8'h21; end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
